// File: rtl/sweep_peak_locator_if.sv
// rtl/sweep_peak_locator_if.sv - scan/detector inputs and peak result outputs of the sweep peak locator
interface sweep_peak_locator_if #(
   parameter int SWEEP_CNT_W = 16
);
   logic                    enable;
   logic signed [13:0]      ramp;
   logic                    sync;
   logic signed [13:0]      sig;
   logic signed [13:0]      threshold;
   logic signed [13:0]      peak_value;
   logic signed [13:0]      peak_ramp;
   logic [31:0]             period;
   logic                    found;
   logic                    valid;
   logic                    timeout;
   logic [SWEEP_CNT_W-1:0]  sweep_count;

   modport master (
      output enable, ramp, sync, sig, threshold,
      input  peak_value, peak_ramp, period, found, valid, timeout, sweep_count
   );

   modport slave (
      input  enable, ramp, sync, sig, threshold,
      output peak_value, peak_ramp, period, found, valid, timeout, sweep_count
   );
endinterface

// File: rtl/sweep_peak_locator.sv
// rtl/sweep_peak_locator.sv - per-sweep detector maximum, ramp position of the maximum and sweep period
module sweep_peak_locator #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000,
   parameter int          SWEEP_CNT_W    = 16
) (
   input logic               clock,
   input logic               reset,
   sweep_peak_locator_if.slave bus
);
   typedef enum logic {S_IDLE, S_TRACK} state_t;

   state_t                  r_state;
   logic                    r_sync_d;
   logic signed [13:0]      r_cur_max;
   logic signed [13:0]      r_cur_ramp;
   logic [31:0]             r_cnt;
   logic signed [13:0]      r_peak_value;
   logic signed [13:0]      r_peak_ramp;
   logic [31:0]             r_period;
   logic                    r_found;
   logic                    r_valid;
   logic                    r_timeout;
   logic [SWEEP_CNT_W-1:0]  r_sweep_count;

   logic w_rise;
   assign w_rise = bus.sync & ~r_sync_d;

   // The rise-cycle sample always opens the new sweep; it never counts toward the closing one.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_sync_d      <= 1'b1;
         r_cur_max     <= '0;
         r_cur_ramp    <= '0;
         r_cnt         <= '0;
         r_peak_value  <= '0;
         r_peak_ramp   <= '0;
         r_period      <= '0;
         r_found       <= 1'b0;
         r_valid       <= 1'b0;
         r_timeout     <= 1'b0;
         r_sweep_count <= '0;
      end else begin
         r_sync_d <= bus.sync;
         r_valid  <= 1'b0;
         if (!bus.enable) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_rise) begin
                     r_state    <= S_TRACK;
                     r_cur_max  <= bus.sig;
                     r_cur_ramp <= bus.ramp;
                     r_cnt      <= 32'd1;
                  end
               end
               S_TRACK: begin
                  if (w_rise) begin
                     r_peak_value  <= r_cur_max;
                     r_peak_ramp   <= r_cur_ramp;
                     r_period      <= r_cnt;
                     r_found       <= (r_cur_max >= bus.threshold);
                     r_sweep_count <= r_sweep_count + SWEEP_CNT_W'(1);
                     r_valid       <= 1'b1;
                     r_timeout     <= 1'b0;
                     r_cur_max     <= bus.sig;
                     r_cur_ramp    <= bus.ramp;
                     r_cnt         <= 32'd1;
                  end else if (r_cnt == TIMEOUT_CYCLES) begin
                     r_timeout <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     if (bus.sig > r_cur_max) begin
                        r_cur_max  <= bus.sig;
                        r_cur_ramp <= bus.ramp;
                     end
                     if (r_cnt != 32'hFFFF_FFFF) begin
                        r_cnt <= r_cnt + 32'd1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.peak_value  = r_peak_value;
   assign bus.peak_ramp   = r_peak_ramp;
   assign bus.period      = r_period;
   assign bus.found       = r_found;
   assign bus.valid       = r_valid;
   assign bus.timeout     = r_timeout;
   assign bus.sweep_count = r_sweep_count;
endmodule

// File: tb/tb_sweep_peak_locator.sv
// tb/tb_sweep_peak_locator.sv - scoreboard bench for sweep_peak_locator against a sample-list reference model
module tb_sweep_peak_locator;
   localparam int TMO = 64;
   localparam int CW  = 16;

   logic clock;
   logic reset;

   sweep_peak_locator_if #(.SWEEP_CNT_W(CW)) bus ();

   sweep_peak_locator #(
      .TIMEOUT_CYCLES (32'(TMO)),
      .SWEEP_CNT_W    (CW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic signed [13:0] pv;
      logic signed [13:0] pr;
      logic [31:0]        per;
      logic               fnd;
      logic [CW-1:0]      cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   // Reference model: the open sweep is simply the list of samples seen since its rise.
   logic signed [13:0] m_sig[$];
   logic signed [13:0] m_ramp[$];
   logic               m_active;
   logic               m_prev;
   logic               m_timeout;
   logic [CW-1:0]      m_count;

   logic signed [13:0] sig_tab[0:127];
   logic signed [13:0] ramp_tab[0:127];

   task automatic chk(string name, int got, int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic model_reset();
      m_sig.delete();
      m_ramp.delete();
      m_active  = 1'b0;
      m_prev    = 1'b1;
      m_timeout = 1'b0;
      m_count   = '0;
      exp_q.delete();
   endtask

   task automatic model_step(logic en, logic sy, logic signed [13:0] sg, logic signed [13:0] rp,
                             logic signed [13:0] th);
      logic rise;
      int   bi;
      exp_t x;
      rise   = sy && !m_prev;
      m_prev = sy;
      if (!en) begin
         m_active = 1'b0;
         m_sig.delete();
         m_ramp.delete();
      end else if (rise) begin
         if (m_active) begin
            bi = 0;
            for (int i = 1; i < m_sig.size(); i++)
               if (m_sig[i] > m_sig[bi]) bi = i;
            m_count = m_count + 1'b1;
            x.pv  = m_sig[bi];
            x.pr  = m_ramp[bi];
            x.per = 32'(m_sig.size());
            x.fnd = (m_sig[bi] >= th);
            x.cnt = m_count;
            exp_q.push_back(x);
            m_timeout = 1'b0;
         end
         m_active = 1'b1;
         m_sig.delete();
         m_ramp.delete();
         m_sig.push_back(sg);
         m_ramp.push_back(rp);
      end else if (m_active) begin
         if (m_sig.size() == TMO) begin
            m_timeout = 1'b1;
            m_active  = 1'b0;
            m_sig.delete();
            m_ramp.delete();
         end else begin
            m_sig.push_back(sg);
            m_ramp.push_back(rp);
         end
      end
   endtask

   task automatic step(logic en, logic sy, logic signed [13:0] sg, logic signed [13:0] rp);
      bus.enable = en;
      bus.sync   = sy;
      bus.sig    = sg;
      bus.ramp   = rp;
      model_step(en, sy, sg, rp, bus.threshold);
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      model_reset();
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
      #1;
      reset = 1'b0;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_peak_value"}, int'(bus.peak_value), 0);
      chk({tag, "_peak_ramp"}, int'(bus.peak_ramp), 0);
      chk({tag, "_period"}, int'(bus.period), 0);
      chk({tag, "_found"}, int'(bus.found), 0);
      chk({tag, "_valid"}, int'(bus.valid), 0);
      chk({tag, "_timeout"}, int'(bus.timeout), 0);
      chk({tag, "_sweep_count"}, int'(bus.sweep_count), 0);
   endtask

   // One sweep starting with a sync rise: high for the first half, low for the rest.
   task automatic sweep(int len, int en_lo, int en_hi);
      for (int i = 0; i < len; i++)
         step(!(i >= en_lo && i < en_hi), (i < (len + 1) / 2), sig_tab[i], ramp_tab[i]);
   endtask

   task automatic fill(logic signed [13:0] base);
      for (int i = 0; i < 128; i++) begin
         sig_tab[i]  = base;
         ramp_tab[i] = 14'(i * 7 - 300);
      end
   endtask

   task automatic fill_random();
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 128; i++) begin
         ramp_tab[i] = 14'($urandom);
         case (mode)
            0: sig_tab[i] = 14'($urandom);
            1: sig_tab[i] = 14'(int'($urandom_range(0, 6)) - 3);
            2: case ($urandom_range(0, 3))
                  0: sig_tab[i] = -14'sd8192;
                  1: sig_tab[i] = 14'sd8191;
                  2: sig_tab[i] = -14'sd8191;
                  default: sig_tab[i] = 14'sd0;
               endcase
            default: sig_tab[i] = ($urandom_range(0, 15) == 0) ? 14'($urandom) : -14'sd5000;
         endcase
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         chk("timeout", int'(bus.timeout), int'(m_timeout));
         if (bus.valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("peak_value", int'(bus.peak_value), int'(e.pv));
               chk("peak_ramp", int'(bus.peak_ramp), int'(e.pr));
               chk("period", int'(bus.period), int'(e.per));
               chk("found", int'(bus.found), int'(e.fnd));
               chk("sweep_count", int'(bus.sweep_count), int'(e.cnt));
            end
         end else if (exp_q.size() != 0) begin
            chk("missing_valid", 0, 1);
            exp_q.delete();
         end
      end
   end

   initial begin
      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.sync      = 1'b1;
      bus.sig       = '0;
      bus.ramp      = '0;
      bus.threshold = '0;
      model_reset();
      @(negedge clock);
      do_reset(3);
      check_zero("reset");

      // Sync held high across release: no edge, no sweep.
      repeat (4) step(1'b1, 1'b1, 14'sd0, 14'sd0);
      repeat (5) step(1'b1, 1'b0, 14'sd0, 14'sd0);

      bus.threshold = 14'sd100;
      fill(14'sd0);
      sig_tab[15] = 14'sd500;
      ramp_tab[15] = 14'sd1200;
      sweep(50, -1, -1);
      fill(14'sd0);
      sig_tab[10] = 14'sd300; ramp_tab[10] = -14'sd400;
      sig_tab[20] = 14'sd300; ramp_tab[20] = 14'sd800;
      sweep(50, -1, -1);
      bus.threshold = -14'sd8191;
      fill(-14'sd8192);
      sweep(30, -1, -1);
      bus.threshold = 14'sd1000;
      fill(14'sd0);
      sig_tab[5] = 14'sd500;
      sweep(20, -1, -1);
      fill(14'sd0);
      sig_tab[7] = 14'sd1000;
      sweep(20, -1, -1);
      fill(14'sd8191);
      sweep(2, -1, -1);
      sweep(2, -1, -1);

      // Timeout: long low phase after a rise, then two normal sweeps.
      fill(14'sd0);
      sweep(90, -1, -1);
      sweep(40, -1, -1);
      sweep(40, -1, -1);

      // Enable dropped and restored inside a sweep.
      sweep(30, 10, 14);
      sweep(30, -1, -1);
      sweep(30, -1, -1);

      for (int n = 0; n < 300; n++) begin
         fill_random();
         bus.threshold = 14'($urandom);
         if ($urandom_range(0, 9) == 0)
            sweep(int'($urandom_range(65, 110)), -1, -1);
         else if ($urandom_range(0, 9) == 0)
            sweep(int'($urandom_range(4, 60)), int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
         else
            sweep(int'($urandom_range(2, 60)), -1, -1);
      end
      sweep(20, -1, -1);

      // Reset in the middle of a sweep.
      fill(14'sd0);
      for (int i = 0; i < 12; i++) step(1'b1, (i < 6), sig_tab[i], ramp_tab[i]);
      do_reset(2);
      check_zero("midreset");

      chk("pending_results", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sweep_peak_locator.md
Name: sweep_peak_locator

Overview:
- Consumes the scan side of the ramp/sync interface: a 14-bit signed ramp value plus the 1-bit midpoint sync pulse produced by the triangle scan generator.
- Also samples a 14-bit signed detector signal, e.g. transmission or error ADC.
- Per sweep period it finds the maximum detector sample and the ramp value at which it occurred, and reports the period length in clocks.
- Feeds lock-acquisition logic, which uses peak_ramp as the PID setpoint or offset, and host readback registers.

Parameters:
- TIMEOUT_CYCLES, 32'd100000000: clocks without a sync rising edge before a sweep is abandoned.
- SWEEP_CNT_W, 16: width of the completed-sweep counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  tracking enable; low forces IDLE
- ramp  in  14 signed  current scan ramp value
- sync  in  1  scan sync, high while ramp above midpoint
- sig  in  14 signed  detector sample
- threshold  in  14 signed  minimum peak counted as a found peak
- peak_value  out  14 signed  max sig in last completed sweep
- peak_ramp  out  14 signed  ramp value at that max
- period  out  32  clocks in last completed sweep
- found  out  1  peak_value >= threshold for last sweep
- valid  out  1  one-clock strobe: new results latched
- timeout  out  1  sticky: sweep abandoned for lack of sync edge
- sweep_count  out  SWEEP_CNT_W  completed sweeps, wraps to 0

Behaviour:
- Reset: clock = clock; reset = reset, synchronous, active-high.
  - All outputs reset to 0; state = IDLE; internal tracking regs = 0.
  - sync_d resets to 1, so a sync already high at reset release is not treated as an edge.
- Edge detect: sync_d <= sync every cycle. rise = sync & ~sync_d.
- States: IDLE, TRACK.
- IDLE:
  - On rise & enable: go to TRACK.
  - Init cur_max = sig, cur_ramp = ramp (the rise-cycle sample), cnt = 1.
- TRACK, every cycle with no rise:
  - If sig > cur_max (signed, strict): cur_max <= sig and cur_ramp <= ramp.
  - Ties keep the earliest sample.
  - cnt <= cnt + 1, saturating at 32'hFFFFFFFF.
- TRACK, on rise (cycle N):
  - Cycle N+1: peak_value <= cur_max, peak_ramp <= cur_ramp, period <= cnt, found <= (cur_max >= threshold signed), sweep_count <= sweep_count + 1 (wraps).
  - valid = 1 for exactly that one cycle.
  - timeout <= 0.
  - The rise-cycle sample re-initialises tracking as in IDLE, with cnt = 1. The rise sample belongs to the new sweep, never the old one.
  - Sweep boundary latency: 1 clock; results cover samples from the previous rise through N-1.
- TRACK, when cnt == TIMEOUT_CYCLES and no rise this cycle:
  - timeout <= 1 (sticky); go to IDLE.
  - Result outputs hold; no valid.
  - A rise in the same cycle takes priority: normal completion, no timeout.
- enable low in any state:
  - Next state IDLE; partial sweep discarded; no valid; outputs hold.
  - timeout unchanged.
  - Re-enable requires a fresh rise.
- valid is only ever high in the cycle immediately after a TRACK rise, never two consecutive cycles unless rises occur on consecutive cycles. Back-to-back rises need sync to toggle, so they occur at minimum every 2 clocks, and each produces period = 2.
- Reset mid-sweep: immediate return to reset values, no valid.
- All comparisons are signed 14-bit; extreme values -8192 and 8191 must be handled with no overflow. threshold is sampled at the completion cycle.
- found and timeout are independent; found refers only to the last valid result.

Test Plan:
1. Assert reset for 3 cycles with sync=1 -> all outputs 0. Release with sync held high -> no valid and state IDLE, confirming no false edge.
2. threshold=100, enable=1. sync rises at cycle 10; sig=0 except sig=500 at cycle 25 with ramp=1200; next sync rise at cycle 60 -> valid at cycle 61 only, peak_value=500, peak_ramp=1200, period=50, found=1, sweep_count=1.
3. Tie: sig=300 at cycle 20 (ramp=-400) and at cycle 30 (ramp=800), all other sig lower -> peak_ramp=-400. Separately, sig=-8192 all sweep -> peak_value=-8192, found=0 with threshold=-8191.
4. threshold=1000, peak 500 -> valid pulses, found=0. A following sweep with peak 1000 -> found=1 (equality counts).
5. TIMEOUT_CYCLES=64, one rise and then sync held low -> timeout=1 at cycle rise+65, no valid, outputs unchanged. Two further rises 40 cycles apart -> valid, period=40, timeout=0.
6. enable dropped at mid-sweep, then restored before the next rise -> no valid on that rise; the following rise gives valid. Reset asserted mid-sweep -> outputs 0, sweep_count=0.
